// File: rtl/picodevice_axi_ram.sv
// AXI4-lite responder RAM for the picodevice mem_axi master: one word array with
// byte strobes, independent write and read channels, one outstanding transaction each.
module picodevice_axi_ram #(
    parameter int    MEM_ADDR_BITS = 10,
    parameter string INIT_FILE     = ""
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,

    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,

    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,

    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,

    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,

    output logic [0:0]  dbg_rd_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and ready depends only on internal state.

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RESP = 1'b1;

    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic                     aw_held_q, aw_held_d;
    logic [MEM_ADDR_BITS-1:0] aw_idx_q,  aw_idx_d;
    logic                     w_held_q,  w_held_d;
    logic [31:0]              w_data_q,  w_data_d;
    logic [3:0]               w_strb_q,  w_strb_d;
    logic                     bvalid_q,  bvalid_d;

    logic                     aw_hs, w_hs, commit;
    logic [MEM_ADDR_BITS-1:0] wr_idx;
    logic [31:0]              wr_data;
    logic [3:0]               wr_strb;

    assign mem_axi_awready = ~aw_held_q & ~bvalid_q;
    assign mem_axi_wready  = ~w_held_q & ~bvalid_q;
    assign mem_axi_bvalid  = bvalid_q;

    assign aw_hs  = mem_axi_awvalid & mem_axi_awready;
    assign w_hs   = mem_axi_wvalid & mem_axi_wready;
    assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

    // A held item wins over the bus: the live side is the one completing the pair.
    assign wr_idx  = aw_held_q ? aw_idx_q : mem_axi_awaddr[MEM_ADDR_BITS+1:2];
    assign wr_data = w_held_q ? w_data_q : mem_axi_wdata;
    assign wr_strb = w_held_q ? w_strb_q : mem_axi_wstrb;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = mem_axi_awaddr[MEM_ADDR_BITS+1:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = mem_axi_wdata;
                w_strb_d = mem_axi_wstrb;
            end
            if (bvalid_q && mem_axi_bready) begin
                bvalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        aw_idx_q <= aw_idx_d;
        w_data_q <= w_data_d;
        w_strb_q <= w_strb_d;
    end

    // Memory is never cleared; a commit edge that coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [0:0]               rd_state_q, rd_state_d;
    logic [31:0]              rdata_q;
    logic                     ar_hs;
    logic [MEM_ADDR_BITS-1:0] rd_idx;

    assign mem_axi_arready = (rd_state_q == RD_IDLE);
    assign mem_axi_rvalid  = (rd_state_q == RD_RESP);
    assign mem_axi_rdata   = rdata_q;
    assign dbg_rd_state_o  = rd_state_q;

    assign ar_hs  = mem_axi_arvalid & mem_axi_arready;
    assign rd_idx = mem_axi_araddr[MEM_ADDR_BITS+1:2];

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (mem_axi_rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Nonblocking read of mem_q gives read-first behaviour against a same-edge commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RD_IDLE;
            rdata_q    <= 32'h0;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                rdata_q <= mem_q[rd_idx];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                           mem_axi_awaddr[31:MEM_ADDR_BITS+2], mem_axi_awaddr[1:0],
                           mem_axi_araddr[31:MEM_ADDR_BITS+2], mem_axi_araddr[1:0]};

endmodule

// File: tb/tb_picodevice_axi_ram.sv
// Self-checking bench for picodevice_axi_ram: table vectors, hand-written channel
// corner sequences, and randomized traffic against a word-array reference model.
module tb_picodevice_axi_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic        arvalid = 1'b0, rready = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] rdata;
    logic [0:0]  dbg_rd_state;

    int total = 0;
    int passed = 0;

    logic [31:0] mem_m [1024];

    picodevice_axi_ram dut (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
        .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
        .mem_axi_rdata(rdata),
        .dbg_rd_state_o(dbg_rd_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
        mem_m[widx(a)] = (mem_m[widx(a)] & ~mask) | (d & mask);
    endtask

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly);
        int  n;
        bit  aw_f, w_f, aw_done, w_done;
        @(negedge clk);
        bready = 1'b1;
        n = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && n < 64) begin
            if (!aw_done && n >= aw_dly) begin awvalid = 1'b1; awaddr = a; end
            if (!w_done && n >= w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            aw_f = awvalid & awready;
            w_f  = wvalid & wready;
            @(negedge clk); n++;
            if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
            if (w_f) begin wvalid = 1'b0; w_done = 1; end
        end
        while (!bvalid && n < 64) begin @(negedge clk); n++; end
        check("write_bvalid", {31'b0, bvalid}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d, s);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        bit ar_f;
        @(negedge clk);
        rready = 1'b1;
        arvalid = 1'b1; araddr = a;
        n = 0; ar_f = 0;
        while (!ar_f && n < 64) begin
            ar_f = arready;
            @(negedge clk); n++;
        end
        arvalid = 1'b0;
        while (!rvalid && n < 64) begin @(negedge clk); n++; end
        check("read_rvalid", {31'b0, rvalid}, 32'd1);
        d = rdata;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          aw_dly;
        int          w_dly;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] got;
        logic [31:0] a, d;
        logic [3:0]  s;

        vecs[0] = '{"full_word",   32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[1] = '{"w_late",      32'h0000_0014, 32'h1122_3344, 4'hF, 0, 2, 32'h0000_0014, 32'h1122_3344};
        vecs[2] = '{"strb_1010",   32'h0000_0014, 32'hAABB_CCDD, 4'hA, 2, 0, 32'h0000_0014, 32'hAA22_CC44};
        vecs[3] = '{"alias_1004",  32'h0000_1004, 32'h1234_5678, 4'hF, 1, 1, 32'h0000_0004, 32'h1234_5678};
        vecs[4] = '{"base_18",     32'h0000_0018, 32'h0102_0304, 4'hF, 0, 3, 32'h0000_0018, 32'h0102_0304};
        vecs[5] = '{"strb_zero",   32'h0000_0018, 32'hFFFF_FFFF, 4'h0, 0, 0, 32'h0000_001A, 32'h0102_0304};
        vecs[6] = '{"word0",       32'h0000_0000, 32'h0000_0000, 4'hF, 0, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{"alias_hi",    32'h0000_2003, 32'hCAFE_BABE, 4'hC, 3, 1, 32'h0000_3000, 32'hCAFE_0000};
        vecs[8] = '{"strb_0001",   32'hFFFF_F004, 32'h0000_00EE, 4'h1, 0, 1, 32'h0000_0004, 32'h1234_56EE};

        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_bvalid",  {31'b0, bvalid},  32'd0);
        check("rst_rvalid",  {31'b0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_awready", {31'b0, awready}, 32'd1);
        check("rst_wready",  {31'b0, wready},  32'd1);
        check("rst_arready", {31'b0, arready}, 32'd1);
        check("rst_dbg",     {31'b0, dbg_rd_state}, 32'd0);

        // table vectors
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].aw_dly, vecs[i].w_dly);
            axi_read(vecs[i].ra, got);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // W captured 3 cycles ahead of AW, then B held off for 5 cycles
        @(negedge clk);
        bready = 1'b0;
        wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_early_wready", {31'b0, wready}, 32'd0);
        repeat (2) @(negedge clk);
        check("w_early_nob", {31'b0, bvalid}, 32'd0);
        awvalid = 1'b1; awaddr = 32'h0000_0010;
        @(negedge clk);
        awvalid = 1'b0;
        model_write(32'h10, 32'h1122_3344, 4'b0101);
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid", {31'b0, bvalid}, 32'd1);
            check("bhold_ready", {30'b0, awready, wready}, 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("b_done_bvalid", {31'b0, bvalid}, 32'd0);
        check("b_done_ready", {30'b0, awready, wready}, 32'd3);
        axi_read(32'h10, got);
        check("w_early_data", got, 32'hDE22_BE44);

        // R held off 4 cycles while a write runs alongside
        @(negedge clk);
        rready = 1'b0; bready = 1'b1;
        arvalid = 1'b1; araddr = 32'h10;
        awvalid = 1'b1; awaddr = 32'h20;
        wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        model_write(32'h20, 32'hCAFE_F00D, 4'hF);
        check("conc_bvalid", {31'b0, bvalid}, 32'd1);
        check("rhold_dbg", {31'b0, dbg_rd_state}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("rhold_rvalid", {31'b0, rvalid}, 32'd1);
            check("rhold_arready", {31'b0, arready}, 32'd0);
            check("rhold_rdata", rdata, mem_m[widx(32'h10)]);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        check("r_done_rvalid", {31'b0, rvalid}, 32'd0);
        axi_read(32'h20, got);
        check("conc_write_data", got, 32'hCAFE_F00D);

        // same-edge write commit and read of one word: read-first
        axi_write(32'h8, 32'h5555_5555, 4'hF, 0, 0);
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h8;
        wvalid = 1'b1; wdata = 32'hAAAA_AAAA; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h8;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_rvalid", {31'b0, rvalid}, 32'd1);
        check("coll_old", rdata, 32'h5555_5555);
        check("coll_bvalid", {31'b0, bvalid}, 32'd1);
        model_write(32'h8, 32'hAAAA_AAAA, 4'hF);
        @(negedge clk);
        axi_read(32'h8, got);
        check("coll_new", got, 32'hAAAA_AAAA);

        // commit edge coinciding with reset leaves memory alone
        axi_write(32'h34, 32'h1111_1111, 4'hF, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        awvalid = 1'b1; awaddr = 32'h34;
        wvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF;
        @(negedge clk);
        reset = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("rstcommit_bvalid", {31'b0, bvalid}, 32'd0);
        axi_read(32'h34, got);
        check("rstcommit_mem", got, 32'h1111_1111);

        // held AW dropped by reset, then lone W must not commit
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h30;
        @(negedge clk);
        awvalid = 1'b0;
        check("aw_held_awready", {31'b0, awready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_outs", {26'b0, awready, wready, arready, bvalid, rvalid, 1'b0}, 32'b111000);
        check("post_rst_rdata", rdata, 32'd0);
        wvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 1'b0;
        check("lone_w_wready", {31'b0, wready}, 32'd0);
        repeat (3) @(negedge clk);
        check("lone_w_nob", {31'b0, bvalid}, 32'd0);
        awvalid = 1'b1; awaddr = 32'h3C;
        @(negedge clk);
        awvalid = 1'b0;
        check("lone_w_pair_b", {31'b0, bvalid}, 32'd1);
        model_write(32'h3C, 32'h7777_7777, 4'hF);
        @(negedge clk);
        axi_read(32'h3C, got);
        check("lone_w_data", got, 32'h7777_7777);

        // randomized traffic over 16 words with aliased addresses
        for (int i = 0; i < 16; i++) axi_write(i * 4, $urandom(), 4'hF, 0, 0);
        for (int i = 0; i < 120; i++) begin
            a = ($urandom() & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                axi_read(a, got);
                check("rand_read", got, mem_m[widx(a)]);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
